// File: rtl/seq_sort_n.sv
// seq_sort_n: collects N words one handshake at a time, sorts them in place
// with N odd-even transposition phases (one per clock), then presents the
// ascending vector (slot 0 = min, slot N-1 = max) until the consumer takes it.
module seq_sort_n #(
  parameter int W      = 8,
  parameter int N      = 4,
  parameter bit SIGNED = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           abort,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic [W-1:0]   out_max,
  output logic [W-1:0]   out_min
);

  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {LOAD, SORT, DONE} state_t;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [CW-1:0]         phase, phase_nx;
  logic                  in_ready_nx, out_valid_nx;
  logic [N-1:0][W-1:0]   slot, slot_nx;
  logic                  accept, last_phase, sort_step;

  // Strict greater-than; equal words never swap, so the sort is stable on ties.
  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    if (SIGNED) return sa > sb;
    else        return a > b;
  endfunction

  assign accept     = (state == LOAD) && in_valid && in_ready && !abort;
  assign last_phase = (phase == CW'(N - 1));
  assign sort_step  = (state == SORT) && !abort;

  // One transposition phase: even phases pair (0,1),(2,3)..., odd phases (1,2),(3,4)...
  always_comb begin
    slot_nx = slot;
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == phase[0] && gt(slot[i], slot[i+1])) begin
        slot_nx[i]   = slot[i+1];
        slot_nx[i+1] = slot[i];
      end
    end
  end

  // Next-state and handshake flags; abort flushes to LOAD from any state.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    phase_nx     = phase;
    in_ready_nx  = in_ready;
    out_valid_nx = out_valid;
    if (abort) begin
      state_nx     = LOAD;
      cnt_nx       = '0;
      phase_nx     = '0;
      in_ready_nx  = 1'b1;
      out_valid_nx = 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (accept) begin
            if (cnt == CW'(N - 1)) begin
              state_nx    = SORT;
              cnt_nx      = '0;
              phase_nx    = '0;
              in_ready_nx = 1'b0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        SORT: begin
          if (last_phase) begin
            state_nx     = DONE;
            out_valid_nx = 1'b1;
          end else begin
            phase_nx = phase + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_nx     = LOAD;
            cnt_nx       = '0;
            out_valid_nx = 1'b0;
            in_ready_nx  = 1'b1;
          end
        end
        default: begin
          state_nx     = LOAD;
          cnt_nx       = '0;
          phase_nx     = '0;
          in_ready_nx  = 1'b1;
          out_valid_nx = 1'b0;
        end
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      phase     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      phase     <= phase_nx;
      in_ready  <= in_ready_nx;
      out_valid <= out_valid_nx;
    end
  end

  // Slot storage and result register; the last phase result is captured directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot     <= '0;
      out_data <= '0;
    end else begin
      if (accept)         slot[cnt] <= in_data;
      else if (sort_step) slot      <= slot_nx;
      if (sort_step && last_phase) out_data <= slot_nx;
    end
  end

  assign out_max = out_data[W*(N-1) +: W];
  assign out_min = out_data[0 +: W];

endmodule

// File: tb/tb_seq_sort_n.sv
// Directed bench for seq_sort_n: N=4 unsigned and signed instances share one
// stimulus stream; a separate N=5 signed instance runs randomised jobs
// against a reference insertion sort.
module tb_seq_sort_n;

  logic        clk = 1'b0;
  logic        rst, abort, in_valid, out_ready;
  logic [7:0]  in_data;
  logic        rdy_u, vld_u, rdy_s, vld_s;
  logic [31:0] dat_u, dat_s;
  logic [7:0]  max_u, min_u, max_s, min_s;

  logic        r_abort, r_valid, r_ready, r_inrdy, r_outvld;
  logic [7:0]  r_data, r_max, r_min;
  logic [39:0] r_out;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_sort_n #(.W(8), .N(4), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy_u),
    .in_data(in_data), .out_valid(vld_u), .out_ready(out_ready), .out_data(dat_u),
    .out_max(max_u), .out_min(min_u));

  seq_sort_n #(.W(8), .N(4), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .abort(abort), .in_valid(in_valid), .in_ready(rdy_s),
    .in_data(in_data), .out_valid(vld_s), .out_ready(out_ready), .out_data(dat_s),
    .out_max(max_s), .out_min(min_s));

  seq_sort_n #(.W(8), .N(5), .SIGNED(1'b1)) dut_r (
    .clk(clk), .rst(rst), .abort(r_abort), .in_valid(r_valid), .in_ready(r_inrdy),
    .in_data(r_data), .out_valid(r_outvld), .out_ready(r_ready), .out_data(r_out),
    .out_max(r_max), .out_min(r_min));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    in_valid = 1'b1;
    in_data = a; step();
    in_data = b; step();
    in_data = c; step();
    in_data = d; step();
    in_valid = 1'b0;
  endtask

  // Checks out_valid stays low for N-1 cycles and rises on the Nth.
  task automatic wait_sorted(input string tag);
    for (int k = 1; k <= 4; k++) begin
      chk({tag, "_vld_u"}, 64'(vld_u), 64'(k == 4));
    end_hack:
      step();
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_vld", 64'(vld_u), 64'd0);
    chk("release_rdy", 64'(rdy_u), 64'd1);
  endtask

  logic signed [7:0] words [5];
  logic signed [7:0] tmp;
  logic [63:0]       exp_r;
  int                got, lat, gap;

  initial begin
    rst = 1'b1; abort = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    r_abort = 1'b0; r_valid = 1'b0; r_data = '0; r_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(rdy_u), 64'd1);
    chk("rst_out_valid", 64'(vld_u), 64'd0);
    chk("rst_out_data", 64'(dat_u), 64'd0);

    // Basic sort with latency check
    load4(8'd5, 8'd200, 8'd17, 8'd90);
    chk("t1_in_ready_low", 64'(rdy_u), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      chk("t1_latency", 64'(vld_u), 64'd0);
      step();
    end
    chk("t1_out_valid", 64'(vld_u), 64'd1);
    chk("t1_data_u", 64'(dat_u), 64'hC85A1105);
    chk("t1_max_u", 64'(max_u), 64'd200);
    chk("t1_min_u", 64'(min_u), 64'd5);
    chk("t1_data_s", 64'(dat_s), 64'h5A1105C8);
    release_out();

    // Duplicates
    load4(8'd7, 8'd7, 8'd3, 8'd7);
    repeat (4) step();
    chk("t2_dup_vld", 64'(vld_u), 64'd1);
    chk("t2_dup_data", 64'(dat_u), 64'h07070703);
    release_out();
    load4(8'd9, 8'd9, 8'd9, 8'd9);
    repeat (4) step();
    chk("t2_eq_data", 64'(dat_u), 64'h09090909);
    release_out();

    // Signed versus unsigned ordering
    load4(8'hFF, 8'h01, 8'h80, 8'h7F);
    repeat (4) step();
    chk("t3_data_u", 64'(dat_u), 64'hFF807F01);
    chk("t3_data_s", 64'(dat_s), 64'h7F01FF80);
    chk("t3_max_s", 64'(max_s), 64'h7F);
    chk("t3_min_s", 64'(min_s), 64'h80);

    // Back-pressure in DONE with input pushing
    in_valid = 1'b1; in_data = 8'hAA;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("t4_hold_vld", 64'(vld_u), 64'd1);
      chk("t4_hold_data", 64'(dat_u), 64'hFF807F01);
      chk("t4_hold_rdy", 64'(rdy_u), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    chk("t4_release_vld", 64'(vld_u), 64'd0);
    chk("t4_release_rdy", 64'(rdy_u), 64'd1);

    // Abort after two words, word on abort edge dropped
    in_valid = 1'b1;
    in_data = 8'd99; step();
    in_data = 8'd98; step();
    in_data = 8'h55; abort = 1'b1; step();
    abort = 1'b0; in_valid = 1'b0;
    chk("t5_abort_rdy", 64'(rdy_u), 64'd1);
    chk("t5_abort_vld", 64'(vld_u), 64'd0);
    load4(8'd4, 8'd3, 8'd2, 8'd1);
    repeat (3) step();
    chk("t5_not_early", 64'(vld_u), 64'd0);
    step();
    chk("t5_after_abort_vld", 64'(vld_u), 64'd1);
    chk("t5_after_abort", 64'(dat_u), 64'h04030201);
    release_out();

    // Reset in the middle of a sort
    load4(8'd1, 8'd2, 8'd3, 8'd4);
    step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_rdy", 64'(rdy_u), 64'd1);
    chk("t5_rst_vld", 64'(vld_u), 64'd0);
    chk("t5_rst_data", 64'(dat_u), 64'd0);
    chk("t5_rst_max", 64'(max_u), 64'd0);
    chk("t5_rst_min", 64'(min_u), 64'd0);
    repeat (6) step();
    chk("t5_rst_idle", 64'(vld_u), 64'd0);

    // Randomised jobs on the N=5 signed instance
    for (int j = 0; j < 60; j++) begin
      got = 0;
      while (got < 5) begin
        r_valid = 1'($urandom_range(0, 1));
        r_data  = 8'($urandom);
        if (r_valid) words[got] = r_data;
        step();
        if (r_valid) got++;
      end
      r_valid = 1'b0;
      lat = 0;
      while (!r_outvld && lat < 20) begin
        step();
        lat++;
      end
      chk("t6_latency", 64'(lat), 64'd5);
      for (int a = 1; a < 5; a++) begin
        for (int b = a; b > 0 && words[b-1] > words[b]; b--) begin
          tmp = words[b]; words[b] = words[b-1]; words[b-1] = tmp;
        end
      end
      exp_r = '0;
      for (int a = 0; a < 5; a++) exp_r[8*a +: 8] = words[a];
      chk("t6_sorted", 64'(r_out), exp_r);
      chk("t6_max", 64'(r_max), 64'(exp_r[39:32]));
      gap = $urandom_range(0, 3);
      repeat (gap) step();
      r_ready = 1'b1; step(); r_ready = 1'b0;
      chk("t6_release", 64'(r_outvld), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
